// File: rtl/fifo_seq_pkg.sv
// Shared types and constants for the FIFO sequencing controller and its read-back checker.
package fifo_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FILL,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int CNT_W = 16;
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/fifo_seq_ctrl_checker.sv
// Read-back checker: delays rdreq by the FIFO read latency and compares q against
// the expected incrementing pattern.
module seq_checker
  import fifo_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 rdreq,
  input  logic [DW-1:0]        q,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic             vld_p1;
  logic [CNT_W-1:0] rd_exp_p1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_p1    <= 1'b0;
      rd_exp_p1 <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // p1: q is valid for the read requested one cycle earlier
      vld_p1 <= rdreq;
      if (vld_p1) begin
        rd_exp_p1 <= rd_exp_p1 + 1'b1;
        if (q != rd_exp_p1[DW-1:0]) begin
          err     <= 1'b1;
          err_cnt <= sat_inc(err_cnt);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_seq_ctrl.sv
// Sequencing controller: clears a FIFO, fills it in watermark-bounded bursts with an
// incrementing pattern, drains it in bursts, and checks every word read back.
module fifo_seq_ctrl
  import fifo_seq_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int TOTAL = 1000,
  parameter int HI_WM = 200,
  parameter int LO_WM = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 full,
  input  logic                 empty,
  input  logic [DW-1:0]        q,
  output logic                 sclr,
  output logic                 wrreq,
  output logic [DW-1:0]        data,
  output logic                 rdreq,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 proto_err
);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] HI_C    = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] LO_C    = CNT_W'(LO_WM);

  state_t           state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] left;
  logic [AW:0]      occ;
  logic [CNT_W-1:0] occ_w;
  logic [CNT_W-1:0] fill_len;
  logic [CNT_W-1:0] drain_len;
  logic             run_clr;

  // occ already accounts for every request issued so far, so burst lengths
  // computed here are valid at the edge that issues the first request of a burst.
  always_comb begin
    occ_w     = CNT_W'(occ);
    fill_len  = ((HI_C - occ_w) < (TOTAL_C - wr_cnt)) ? (HI_C - occ_w) : (TOTAL_C - wr_cnt);
    drain_len = occ_w - LO_C;
    run_clr   = (state == S_IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sclr      <= 1'b0;
      wrreq     <= 1'b0;
      rdreq     <= 1'b0;
      data      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      proto_err <= 1'b0;
      wr_cnt    <= '0;
      left      <= '0;
      occ       <= '0;
    end else begin
      sclr <= 1'b0;
      done <= 1'b0;
      if ((wrreq && full) || (rdreq && empty)) proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLR;
            sclr      <= 1'b1;
            busy      <= 1'b1;
            wr_cnt    <= '0;
            occ       <= '0;
            left      <= '0;
            proto_err <= 1'b0;
          end
        end
        S_CLR: begin
          state  <= S_FILL;
          wrreq  <= 1'b1;
          data   <= wr_cnt[DW-1:0];
          wr_cnt <= wr_cnt + 1'b1;
          occ    <= occ + 1'b1;
          left   <= fill_len - 1'b1;
        end
        S_FILL: begin
          if (left != '0) begin
            data   <= wr_cnt[DW-1:0];
            wr_cnt <= wr_cnt + 1'b1;
            occ    <= occ + 1'b1;
            left   <= left - 1'b1;
          end else begin
            state <= (wr_cnt < TOTAL_C) ? S_DRAIN : S_FLUSH;
            wrreq <= 1'b0;
            rdreq <= 1'b1;
            occ   <= occ - 1'b1;
            left  <= (wr_cnt < TOTAL_C) ? drain_len - 1'b1 : occ_w - 1'b1;
          end
        end
        S_DRAIN: begin
          if (left != '0) begin
            occ  <= occ - 1'b1;
            left <= left - 1'b1;
          end else begin
            state  <= S_FILL;
            rdreq  <= 1'b0;
            wrreq  <= 1'b1;
            data   <= wr_cnt[DW-1:0];
            wr_cnt <= wr_cnt + 1'b1;
            occ    <= occ + 1'b1;
            left   <= fill_len - 1'b1;
          end
        end
        S_FLUSH: begin
          // After the last read, wait one cycle for its word to be checked.
          if (rdreq) begin
            if (left != '0) begin
              occ  <= occ - 1'b1;
              left <= left - 1'b1;
            end else begin
              rdreq <= 1'b0;
            end
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  seq_checker #(
    .DW(DW)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .clr    (run_clr),
    .rdreq  (rdreq),
    .q      (q),
    .err    (err),
    .err_cnt(err_cnt)
  );

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Directed bench for fifo_seq_ctrl with a behavioural single-clock FIFO model.
module tb_fifo_seq_ctrl;

  logic clk = 1'b0;
  logic rst, start, sel, force_full;
  int   checks = 0;
  int   failures = 0;
  int   corrupt_at = 0;
  int   bl[$];

  logic       sclr_a, wrreq_a, rdreq_a, busy_a, done_a, err_a, pe_a;
  logic [7:0] data_a, ecnt_a;
  logic       sclr_b, wrreq_b, rdreq_b, busy_b, done_b, err_b, pe_b;
  logic [7:0] data_b, ecnt_b;

  logic       o_sclr, o_wrreq, o_rdreq, o_busy, o_done, o_err, o_pe;
  logic [7:0] o_data, o_ecnt;

  assign o_sclr  = sel ? sclr_b  : sclr_a;
  assign o_wrreq = sel ? wrreq_b : wrreq_a;
  assign o_rdreq = sel ? rdreq_b : rdreq_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_err   = sel ? err_b   : err_a;
  assign o_pe    = sel ? pe_b    : pe_a;
  assign o_data  = sel ? data_b  : data_a;
  assign o_ecnt  = sel ? ecnt_b  : ecnt_a;

  // Behavioural FIFO: normal read, q registered one cycle after rdreq
  logic [7:0] mem [0:255];
  logic [7:0] wp = '0, rp = '0, q_m = '0;
  int         cnt = 0, rd_num = 0;
  logic       m_full, m_empty;
  assign m_full  = force_full || (cnt == 256);
  assign m_empty = (cnt == 0);

  always @(posedge clk) begin
    if (o_sclr) begin
      cnt    <= 0;
      wp     <= '0;
      rp     <= '0;
      rd_num <= 0;
    end else begin
      if (o_wrreq && cnt < 256) begin
        mem[wp] <= o_data;
        wp      <= wp + 8'd1;
      end
      if (o_rdreq && cnt > 0) begin
        q_m    <= mem[rp] ^ ((rd_num + 1 == corrupt_at) ? 8'h01 : 8'h00);
        rp     <= rp + 8'd1;
        rd_num <= rd_num + 1;
      end
      cnt <= cnt + ((o_wrreq && cnt < 256) ? 1 : 0) - ((o_rdreq && cnt > 0) ? 1 : 0);
    end
  end

  fifo_seq_ctrl #(.DW(8), .AW(8), .TOTAL(16), .HI_WM(8), .LO_WM(2)) dut_a (
    .clk(clk), .rst(rst), .start(start && !sel), .full(m_full), .empty(m_empty), .q(q_m),
    .sclr(sclr_a), .wrreq(wrreq_a), .data(data_a), .rdreq(rdreq_a), .busy(busy_a),
    .done(done_a), .err(err_a), .err_cnt(ecnt_a), .proto_err(pe_a)
  );

  fifo_seq_ctrl #(.DW(8), .AW(8), .TOTAL(5), .HI_WM(8), .LO_WM(2)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel), .full(m_full), .empty(m_empty), .q(q_m),
    .sclr(sclr_b), .wrreq(wrreq_b), .data(data_b), .rdreq(rdreq_b), .busy(busy_b),
    .done(done_b), .err(err_b), .err_cnt(ecnt_b), .proto_err(pe_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the sclr cycle; walks the alternating write/read burst table in bl.
  task automatic follow_run(input string tag, input bit hold, input int pe_at,
                            input bit exp_err, input logic [7:0] exp_ecnt);
    int k, wv, reqs, tot;
    k = 0; wv = 0; reqs = 0; tot = 0;
    if (!hold) start = 1'b0;
    chk({tag, ".sclr"}, 32'(o_sclr), 32'd1);
    chk({tag, ".busy0"}, 32'(o_busy), 32'd1);
    chk({tag, ".wr0"}, 32'(o_wrreq), 32'd0);
    chk({tag, ".err_clr"}, 32'(o_err), 32'd0);
    chk({tag, ".ecnt_clr"}, 32'(o_ecnt), 32'd0);
    chk({tag, ".pe_clr"}, 32'(o_pe), 32'd0);
    foreach (bl[i]) begin
      tot += bl[i];
      for (int j = 0; j < bl[i]; j++) begin
        step();
        k++;
        if (o_wrreq || o_rdreq) reqs++;
        chk({tag, ".sclr_lo"}, 32'(o_sclr), 32'd0);
        if (i % 2 == 0) begin
          chk({tag, ".wrreq"}, 32'(o_wrreq), 32'd1);
          chk({tag, ".rd_in_wr"}, 32'(o_rdreq), 32'd0);
          chk({tag, ".data"}, 32'(o_data), 32'(wv));
          wv++;
        end else begin
          chk({tag, ".rdreq"}, 32'(o_rdreq), 32'd1);
          chk({tag, ".wr_in_rd"}, 32'(o_wrreq), 32'd0);
        end
        chk({tag, ".proto_err"}, 32'(o_pe), (pe_at >= 0 && k >= pe_at) ? 32'd1 : 32'd0);
      end
      if (i == 0) force_full = 1'b0;
    end
    step();
    chk({tag, ".tail_rd"}, 32'(o_rdreq), 32'd0);
    chk({tag, ".tail_wr"}, 32'(o_wrreq), 32'd0);
    chk({tag, ".tail_done"}, 32'(o_done), 32'd0);
    step();
    chk({tag, ".done"}, 32'(o_done), 32'd1);
    chk({tag, ".busy_done"}, 32'(o_busy), 32'd1);
    chk({tag, ".err"}, 32'(o_err), 32'(exp_err));
    chk({tag, ".err_cnt"}, 32'(o_ecnt), 32'(exp_ecnt));
    chk({tag, ".pe_end"}, 32'(o_pe), (pe_at >= 0) ? 32'd1 : 32'd0);
    step();
    chk({tag, ".done_lo"}, 32'(o_done), 32'd0);
    chk({tag, ".busy_lo"}, 32'(o_busy), 32'd0);
    chk({tag, ".req_total"}, 32'(reqs), 32'(tot));
  endtask

  task automatic kick();
    start = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; force_full = 1'b0;
    step();
    step();
    chk("rst.sclr", 32'(o_sclr), 32'd0);
    chk("rst.wrreq", 32'(o_wrreq), 32'd0);
    chk("rst.rdreq", 32'(o_rdreq), 32'd0);
    chk("rst.data", 32'(o_data), 32'd0);
    chk("rst.busy", 32'(o_busy), 32'd0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.err", 32'(o_err), 32'd0);
    chk("rst.err_cnt", 32'(o_ecnt), 32'd0);
    chk("rst.proto_err", 32'(o_pe), 32'd0);
    rst = 1'b0;
    step();

    // TOTAL=16, HI=8, LO=2: W8 R6 W6 R6 W2 then flush R4
    bl = '{8, 6, 6, 6, 2, 4};
    kick();
    follow_run("clean", 1'b0, -1, 1'b0, 8'd0);
    step();

    corrupt_at = 4;
    kick();
    follow_run("corrupt", 1'b0, -1, 1'b1, 8'd1);
    corrupt_at = 0;
    step();

    force_full = 1'b1;
    kick();
    follow_run("fullfrc", 1'b0, 2, 1'b0, 8'd0);
    step();

    kick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("midrst.in_drain", 32'(o_rdreq), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst.wrreq", 32'(o_wrreq), 32'd0);
    chk("midrst.rdreq", 32'(o_rdreq), 32'd0);
    chk("midrst.busy", 32'(o_busy), 32'd0);
    chk("midrst.sclr", 32'(o_sclr), 32'd0);
    chk("midrst.data", 32'(o_data), 32'd0);
    rst = 1'b0;
    step();
    kick();
    follow_run("afterrst", 1'b0, -1, 1'b0, 8'd0);
    step();

    // TOTAL=5: one fill of five words straight into flush
    sel = 1'b1;
    bl = '{5, 5};
    kick();
    follow_run("total5", 1'b0, -1, 1'b0, 8'd0);
    step();
    sel = 1'b0;
    step();

    // start held high: back-to-back runs, errors cleared at the second start
    bl = '{8, 6, 6, 6, 2, 4};
    corrupt_at = 4;
    kick();
    follow_run("hold1", 1'b1, -1, 1'b1, 8'd1);
    chk("hold.gap_sclr", 32'(o_sclr), 32'd0);
    corrupt_at = 0;
    step();
    follow_run("hold2", 1'b0, -1, 1'b0, 8'd0);
    step();
    chk("hold.no_third", 32'(o_sclr), 32'd0);
    chk("hold.idle_busy", 32'(o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
